// File: rtl/sparse_block_expander_pkg.sv
// Shared geometry constants, FSM state encoding and beat-count helper for the
// sparse block expander.
package sparse_block_expander_pkg;

   localparam int SBE_BITMASK_LENGTH = 16;
   localparam int SBE_INDEX_BITWIDTH = 5;
   localparam int SBE_ELEMENT_WIDTH  = 8;
   localparam int SBE_BEAT_ELEMENTS  = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_EMIT    = 2'd2
   } state_t;

   // Evaluated in 32 bits so a completely full mask cannot overflow the sum.
   function automatic int unsigned beats_needed(input int unsigned k,
                                                input int unsigned beat_elems);
      return (k + beat_elems - 1) / beat_elems;
   endfunction

endpackage

// File: rtl/sparse_block_expander_prefix_index_counter.sv
// Inclusive running popcount of a bitmask; entry p counts the ones in mask[0..p],
// so the last entry is the total number of set bits.
module prefix_index_counter #(
   parameter int BITMASK_LENGTH = 16,
   parameter int INDEX_BITWIDTH = 5
) (
   input  logic [BITMASK_LENGTH-1:0]                     mask,
   output logic [BITMASK_LENGTH-1:0][INDEX_BITWIDTH-1:0] prefix
);

   logic [INDEX_BITWIDTH-1:0] acc;

   always_comb begin
      acc    = '0;
      prefix = '0;
      for (int p = 0; p < BITMASK_LENGTH; p++) begin
         acc       = acc + INDEX_BITWIDTH'(mask[p]);
         prefix[p] = acc;
      end
   end

endmodule

// File: rtl/sparse_block_expander.sv
// Restores a compacted dense operand block to its bitmask-indexed sparse layout:
// mask first, then dense beats, then one full-width sparse block.
//
// state   | meaning
// IDLE    | waiting for a bitmask; maskReady high
// COLLECT | accepting dense beats until beatsNeeded are in
// EMIT    | sparse block valid and frozen until iready
module sparse_block_expander
   import sparse_block_expander_pkg::*;
#(
   parameter int BITMASK_LENGTH = SBE_BITMASK_LENGTH,
   parameter int INDEX_BITWIDTH = SBE_INDEX_BITWIDTH,
   parameter int ELEMENT_WIDTH  = SBE_ELEMENT_WIDTH,
   parameter int BEAT_ELEMENTS  = SBE_BEAT_ELEMENTS
) (
   input  logic                                      clock,
   input  logic                                      resetn,
   input  logic                                      maskValid,
   output logic                                      maskReady,
   input  logic [BITMASK_LENGTH-1:0]                 bitmask,
   input  logic                                      denseValid,
   output logic                                      denseReady,
   input  logic [BEAT_ELEMENTS*ELEMENT_WIDTH-1:0]    denseData,
   output logic                                      ovalid,
   input  logic                                      iready,
   output logic [BITMASK_LENGTH*ELEMENT_WIDTH-1:0]   sparseOutput,
   output logic [INDEX_BITWIDTH-1:0]                 numDense
);

   localparam int IDX_W = $clog2(BITMASK_LENGTH);

   state_t                                          state_q, state_d;
   logic [BITMASK_LENGTH-1:0]                       mask_q, mask_d;
   logic [INDEX_BITWIDTH-1:0]                       num_dense_q, num_dense_d;
   logic [INDEX_BITWIDTH-1:0]                       beats_needed_q, beats_needed_d;
   logic [INDEX_BITWIDTH-1:0]                       beat_count_q, beat_count_d;
   logic [BITMASK_LENGTH-1:0][ELEMENT_WIDTH-1:0]    dense_q, dense_d;
   logic [BITMASK_LENGTH-1:0][ELEMENT_WIDTH-1:0]    sparse_q, sparse_d;

   logic [BITMASK_LENGTH-1:0]                       count_mask;
   logic [BITMASK_LENGTH-1:0][INDEX_BITWIDTH-1:0]   prefix;
   logic [INDEX_BITWIDTH-1:0]                       k_in;
   logic [BITMASK_LENGTH-1:0][ELEMENT_WIDTH-1:0]    dense_next;
   logic [BITMASK_LENGTH-1:0][ELEMENT_WIDTH-1:0]    expanded;

   // One counter serves both phases: incoming mask for K in IDLE, latched mask
   // for the expansion indices afterwards.
   assign count_mask = (state_q == ST_IDLE) ? bitmask : mask_q;
   assign k_in       = prefix[BITMASK_LENGTH-1];

   prefix_index_counter #(
      .BITMASK_LENGTH (BITMASK_LENGTH),
      .INDEX_BITWIDTH (INDEX_BITWIDTH)
   ) u_prefix (
      .mask   (count_mask),
      .prefix (prefix)
   );

   // Buffer as it will look once the current beat lands, so the final beat can
   // be expanded in the same cycle it is accepted.
   always_comb begin
      dense_next = dense_q;
      for (int e = 0; e < BEAT_ELEMENTS; e++) begin
         dense_next[IDX_W'(int'(beat_count_q) * BEAT_ELEMENTS + e)] =
            denseData[e*ELEMENT_WIDTH +: ELEMENT_WIDTH];
      end
   end

   always_comb begin
      expanded = '0;
      for (int p = 0; p < BITMASK_LENGTH; p++) begin
         if (mask_q[p]) begin
            expanded[p] = dense_next[IDX_W'(prefix[p] - INDEX_BITWIDTH'(1))];
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      mask_d         = mask_q;
      num_dense_d    = num_dense_q;
      beats_needed_d = beats_needed_q;
      beat_count_d   = beat_count_q;
      dense_d        = dense_q;
      sparse_d       = sparse_q;
      maskReady      = 1'b0;
      denseReady     = 1'b0;
      ovalid         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            maskReady = 1'b1;
            if (maskValid) begin
               mask_d         = bitmask;
               num_dense_d    = k_in;
               beats_needed_d = INDEX_BITWIDTH'(beats_needed(32'(k_in), BEAT_ELEMENTS));
               beat_count_d   = '0;
               if (k_in == '0) begin
                  sparse_d = '0;
                  state_d  = ST_EMIT;
               end else begin
                  state_d  = ST_COLLECT;
               end
            end
         end
         ST_COLLECT: begin
            denseReady = 1'b1;
            if (denseValid) begin
               dense_d      = dense_next;
               beat_count_d = beat_count_q + INDEX_BITWIDTH'(1);
               if (beat_count_q + INDEX_BITWIDTH'(1) == beats_needed_q) begin
                  sparse_d = expanded;
                  state_d  = ST_EMIT;
               end
            end
         end
         ST_EMIT: begin
            ovalid = 1'b1;
            if (iready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q        <= ST_IDLE;
         mask_q         <= '0;
         num_dense_q    <= '0;
         beats_needed_q <= '0;
         beat_count_q   <= '0;
         dense_q        <= '0;
         sparse_q       <= '0;
      end else begin
         state_q        <= state_d;
         mask_q         <= mask_d;
         num_dense_q    <= num_dense_d;
         beats_needed_q <= beats_needed_d;
         beat_count_q   <= beat_count_d;
         dense_q        <= dense_d;
         sparse_q       <= sparse_d;
      end
   end

   assign sparseOutput = sparse_q;
   assign numDense     = num_dense_q;

endmodule

// File: tb/tb_sparse_block_expander.sv
// Scoreboard bench for sparse_block_expander: expected blocks are queued as the
// mask and beats are driven, then popped when the DUT presents ovalid.
module tb_sparse_block_expander;

   logic         clock = 1'b0;
   logic         resetn;
   logic         maskValid;
   logic         maskReady;
   logic [15:0]  bitmask;
   logic         denseValid;
   logic         denseReady;
   logic [31:0]  denseData;
   logic         ovalid;
   logic         iready;
   logic [127:0] sparseOutput;
   logic [4:0]   numDense;

   int checks = 0;
   int passed = 0;

   typedef struct {
      logic [127:0] s;
      logic [4:0]   n;
   } exp_t;
   exp_t sb[$];

   sparse_block_expander dut (
      .clock        (clock),
      .resetn       (resetn),
      .maskValid    (maskValid),
      .maskReady    (maskReady),
      .bitmask      (bitmask),
      .denseValid   (denseValid),
      .denseReady   (denseReady),
      .denseData    (denseData),
      .ovalid       (ovalid),
      .iready       (iready),
      .sparseOutput (sparseOutput),
      .numDense     (numDense)
   );

   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   function automatic logic [127:0] expand(input logic [15:0] m, input logic [127:0] d);
      logic [127:0] r;
      int j;
      r = '0;
      j = 0;
      for (int p = 0; p < 16; p++) begin
         if (m[p]) begin
            r[p*8 +: 8] = d[j*8 +: 8];
            j++;
         end
      end
      return r;
   endfunction

   task automatic push_exp(input logic [15:0] m, input logic [127:0] d);
      exp_t e;
      e.s = expand(m, d);
      e.n = 5'($countones(m));
      sb.push_back(e);
   endtask

   task automatic send_mask(input logic [15:0] m);
      int n;
      n = 0;
      maskValid = 1'b1;
      bitmask   = m;
      while (!maskReady && n < 50) begin
         @(posedge clock); #1; n++;
      end
      checks++;
      if (!maskReady) $display("FAIL mask_handshake: maskReady=%0b required 1", maskReady);
      else passed++;
      @(posedge clock); #1;
      maskValid = 1'b0;
      bitmask   = 16'hA5A5;
   endtask

   task automatic send_beat(input logic [31:0] d);
      int n;
      n = 0;
      denseValid = 1'b1;
      denseData  = d;
      while (!denseReady && n < 50) begin
         @(posedge clock); #1; n++;
      end
      checks++;
      if (!denseReady) $display("FAIL beat_handshake: denseReady=%0b required 1", denseReady);
      else passed++;
      @(posedge clock); #1;
      denseValid = 1'b0;
      denseData  = 32'hDEADBEEF;
   endtask

   task automatic drive_block(input logic [15:0] m, input logic [127:0] d, input int nb);
      push_exp(m, d);
      send_mask(m);
      for (int b = 0; b < nb; b++) send_beat(d[b*32 +: 32]);
   endtask

   task automatic get_block(output logic [127:0] s, output logic [4:0] nd, output bit ok);
      int n;
      n = 0;
      iready = 1'b1;
      while (!ovalid && n < 100) begin
         @(posedge clock); #1; n++;
      end
      ok = ovalid;
      s  = sparseOutput;
      nd = numDense;
      @(posedge clock); #1;
      iready = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0; maskValid = 1'b0; denseValid = 1'b0; iready = 1'b0;
      bitmask = '0; denseData = '0;
      repeat (3) @(posedge clock);
      #1;
      checks++; if (ovalid !== 1'b0) $display("FAIL reset_ovalid: got %0b expected 0", ovalid); else passed++;
      checks++; if (denseReady !== 1'b0) $display("FAIL reset_denseReady: got %0b expected 0", denseReady); else passed++;
      checks++; if (sparseOutput !== 128'h0) $display("FAIL reset_sparse: got %h expected 0", sparseOutput); else passed++;
      checks++; if (numDense !== 5'd0) $display("FAIL reset_numDense: got %0d expected 0", numDense); else passed++;
      resetn = 1'b1;
      @(posedge clock); #1;
      checks++; if (maskReady !== 1'b1) $display("FAIL reset_maskReady: got %0b expected 1", maskReady); else passed++;
   endtask

   task automatic test_empty();
      logic [127:0] s; logic [4:0] nd; bit ok; exp_t e;
      push_exp(16'h0000, 128'h0);
      send_mask(16'h0000);
      checks++; if (ovalid !== 1'b1) $display("FAIL empty_latency: ovalid=%0b expected 1", ovalid); else passed++;
      checks++; if (denseReady !== 1'b0) $display("FAIL empty_denseReady: got %0b expected 0", denseReady); else passed++;
      get_block(s, nd, ok);
      e = sb.pop_front();
      checks++; if (!ok) $display("FAIL empty_ovalid: timeout, ovalid=0 expected 1"); else passed++;
      checks++; if (s !== e.s) $display("FAIL empty_sparse: got %h expected %h", s, e.s); else passed++;
      checks++; if (nd !== e.n) $display("FAIL empty_numDense: got %0d expected %0d", nd, e.n); else passed++;
   endtask

   task automatic test_single();
      logic [127:0] s; logic [4:0] nd; bit ok; exp_t e;
      drive_block(16'h0004, 128'h000000AA, 1);
      get_block(s, nd, ok);
      e = sb.pop_front();
      checks++; if (!ok || s !== e.s) $display("FAIL single_sparse: got %h ok=%0b expected %h", s, ok, e.s); else passed++;
      checks++; if (nd !== e.n) $display("FAIL single_numDense: got %0d expected %0d", nd, e.n); else passed++;
   endtask

   task automatic test_full();
      logic [127:0] s, d; logic [4:0] nd; bit ok; exp_t e;
      for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'(i + 1);
      push_exp(16'hFFFF, d);
      send_mask(16'hFFFF);
      for (int b = 0; b < 4; b++) begin
         checks++; if (ovalid !== 1'b0) $display("FAIL full_early_ovalid: beat %0d ovalid=%0b expected 0", b, ovalid); else passed++;
         send_beat(d[b*32 +: 32]);
      end
      checks++; if (ovalid !== 1'b1) $display("FAIL full_latency: ovalid=%0b expected 1", ovalid); else passed++;
      get_block(s, nd, ok);
      e = sb.pop_front();
      checks++; if (!ok || s !== e.s) $display("FAIL full_sparse: got %h ok=%0b expected %h", s, ok, e.s); else passed++;
      checks++; if (nd !== 5'b10000) $display("FAIL full_numDense: got %0d expected 16", nd); else passed++;
   endtask

   task automatic test_partial();
      logic [127:0] s; logic [4:0] nd; bit ok; exp_t e;
      drive_block(16'h8001, 128'hEEDD2211, 1);
      get_block(s, nd, ok);
      e = sb.pop_front();
      checks++; if (!ok || s !== e.s) $display("FAIL partial8001_sparse: got %h ok=%0b expected %h", s, ok, e.s); else passed++;
      checks++; if (nd !== e.n) $display("FAIL partial8001_numDense: got %0d expected %0d", nd, e.n); else passed++;
      drive_block(16'h001F, {64'h0, 32'hCCBBAA55, 32'h44332211}, 2);
      get_block(s, nd, ok);
      e = sb.pop_front();
      checks++; if (!ok || s !== e.s) $display("FAIL partial001F_sparse: got %h ok=%0b expected %h", s, ok, e.s); else passed++;
      checks++; if (nd !== e.n) $display("FAIL partial001F_numDense: got %0d expected %0d", nd, e.n); else passed++;
   endtask

   task automatic test_stall();
      logic [127:0] s, d; logic [4:0] nd; bit ok; exp_t e;
      d = '0;
      for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'(8'h81 + i);
      push_exp(16'h00FF, d);
      send_mask(16'h00FF);
      send_beat(d[31:0]);
      denseValid = 1'b0;
      denseData  = 32'h99999999;
      repeat (3) begin
         @(posedge clock); #1;
         checks++;
         if (denseReady !== 1'b1 || ovalid !== 1'b0)
            $display("FAIL stall_hold: denseReady=%0b ovalid=%0b expected 1/0", denseReady, ovalid);
         else passed++;
      end
      send_beat(d[63:32]);
      checks++; if (ovalid !== 1'b1) $display("FAIL stall_latency: ovalid=%0b expected 1", ovalid); else passed++;
      get_block(s, nd, ok);
      e = sb.pop_front();
      checks++; if (!ok || s !== e.s) $display("FAIL stall_sparse: got %h ok=%0b expected %h", s, ok, e.s); else passed++;
      checks++; if (nd !== e.n) $display("FAIL stall_numDense: got %0d expected %0d", nd, e.n); else passed++;
   endtask

   task automatic test_back_to_back();
      logic [127:0] s, d; logic [4:0] nd; bit ok; exp_t e;
      d = '0;
      for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'(8'h31 + i);
      drive_block(16'h0F0F, d, 2);
      e = sb.pop_front();
      checks++; if (ovalid !== 1'b1) $display("FAIL bp_ovalid: got %0b expected 1", ovalid); else passed++;
      maskValid = 1'b1;
      bitmask   = 16'h0100;
      push_exp(16'h0100, 128'h5A);
      for (int c = 0; c < 5; c++) begin
         @(posedge clock); #1;
         checks++;
         if (sparseOutput !== e.s || numDense !== e.n || maskReady !== 1'b0 || ovalid !== 1'b1)
            $display("FAIL bp_frozen: cycle %0d sparse=%h nd=%0d maskReady=%0b ovalid=%0b expected %h/%0d/0/1",
                     c, sparseOutput, numDense, maskReady, ovalid, e.s, e.n);
         else passed++;
      end
      iready = 1'b1;
      @(posedge clock); #1;
      iready = 1'b0;
      checks++; if (maskReady !== 1'b1 || ovalid !== 1'b0) $display("FAIL bp_release: maskReady=%0b ovalid=%0b expected 1/0", maskReady, ovalid); else passed++;
      @(posedge clock); #1;
      maskValid = 1'b0;
      checks++; if (denseReady !== 1'b1) $display("FAIL bp_next_mask: denseReady=%0b expected 1", denseReady); else passed++;
      send_beat(32'h0000005A);
      get_block(s, nd, ok);
      e = sb.pop_front();
      checks++; if (!ok || s !== e.s) $display("FAIL bp_next_sparse: got %h ok=%0b expected %h", s, ok, e.s); else passed++;
      checks++; if (nd !== e.n) $display("FAIL bp_next_numDense: got %0d expected %0d", nd, e.n); else passed++;
   endtask

   task automatic test_reset_mid();
      logic [127:0] s; logic [4:0] nd; bit ok; exp_t e;
      send_mask(16'hFFFF);
      send_beat(32'h04030201);
      send_beat(32'h08070605);
      resetn = 1'b0;
      #1;
      checks++; if (ovalid !== 1'b0) $display("FAIL rstmid_ovalid: got %0b expected 0", ovalid); else passed++;
      checks++; if (sparseOutput !== 128'h0) $display("FAIL rstmid_sparse: got %h expected 0", sparseOutput); else passed++;
      checks++; if (numDense !== 5'd0) $display("FAIL rstmid_numDense: got %0d expected 0", numDense); else passed++;
      checks++; if (denseReady !== 1'b0) $display("FAIL rstmid_denseReady: got %0b expected 0", denseReady); else passed++;
      @(posedge clock); #1;
      resetn = 1'b1;
      @(posedge clock); #1;
      sb.delete();
      drive_block(16'h0004, 128'h000000AA, 1);
      get_block(s, nd, ok);
      e = sb.pop_front();
      checks++; if (!ok || s !== e.s) $display("FAIL rstmid_next_sparse: got %h ok=%0b expected %h", s, ok, e.s); else passed++;
      checks++; if (nd !== e.n) $display("FAIL rstmid_next_numDense: got %0d expected %0d", nd, e.n); else passed++;
   endtask

   initial begin
      test_reset();
      test_empty();
      test_single();
      test_full();
      test_partial();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/sparse_block_expander.md
# sparse_block_expander

Streaming decompressor that restores a compacted (dense) operand block to its sparse, bit-mask-indexed layout. It inverts the mask-driven compaction performed upstream. It accepts one bitmask, then collects the dense elements in fixed-width beats, then emits one full-width sparse block with zeros in the masked-off positions. It sits between the dense-operand fetch path and the sparse PE operand registers.

## Interface
- BITMASK_LENGTH, 16, elements per sparse block
- INDEX_BITWIDTH, 5, width of counts/indices; must hold BITMASK_LENGTH
- ELEMENT_WIDTH, 8, bits per element
- BEAT_ELEMENTS, 4, dense elements per input beat; must divide BITMASK_LENGTH
- clock  in  1  single clock; all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- maskValid  in  1  bitmask offered
- maskReady  out  1  bitmask accepted when both high
- bitmask  in  BITMASK_LENGTH  little-endian; bit p=1 means sparse position p is non-zero
- denseValid  in  1  dense beat offered
- denseReady  out  1  beat accepted when both high
- denseData  in  BEAT_ELEMENTS*ELEMENT_WIDTH  little-endian dense elements
- ovalid  out  1  sparse block valid
- iready  in  1  downstream accepts block when both high
- sparseOutput  out  BITMASK_LENGTH*ELEMENT_WIDTH  expanded block
- numDense  out  INDEX_BITWIDTH  popcount of the block's bitmask

## Operation
- FSM states: IDLE, COLLECT, EMIT.
- IDLE:
  - maskReady=1.
  - On accept: latch bitmask, K=popcount(bitmask), beatsNeeded=ceil(K/BEAT_ELEMENTS), beatCount=0.
  - Go to COLLECT if K>0, else EMIT.
- COLLECT:
  - denseReady=1.
  - Each accepted beat writes dense buffer slots [beatCount*BEAT_ELEMENTS +: BEAT_ELEMENTS], then beatCount++.
  - On the beat where beatCount+1==beatsNeeded, register the expanded output and go to EMIT.
  - Elements beyond index K-1 in the final (partial) beat are ignored.
- EMIT:
  - ovalid=1. sparseOutput and numDense are held stable.
  - On iready, go to IDLE.
- Expansion: with prefix(p) = inclusive count of ones in bitmask[0..p]:
  - sparseOutput[p] = bitmask[p] ? dense[prefix(p)-1] : 0.
- Arithmetic: all counts unsigned, INDEX_BITWIDTH wide. beatsNeeded = (K + BEAT_ELEMENTS-1)/BEAT_ELEMENTS, computed without overflow for K=BITMASK_LENGTH.
- maskReady, denseReady and ovalid are decoded from state only; no combinational path from any valid/ready input.
- denseValid is ignored outside COLLECT. maskValid is ignored outside IDLE.

## Timing
- Reset (asynchronous assert):
  - state=IDLE, ovalid=0, denseReady=0, sparseOutput=0, numDense=0, beatCount=0, dense buffer=0.
  - maskReady=1 from the first edge after deassertion.
- Latency:
  - K=0: mask accept at cycle t gives ovalid at t+1.
  - K>0: last dense beat accepted at cycle t gives ovalid at t+1.
- Minimum block period: 1 (mask) + beatsNeeded + 1 (emit) cycles. No overlap of consecutive blocks.
- Backpressure: while ovalid=1 and iready=0, all outputs are frozen and maskReady=0.
- A stall of denseValid in COLLECT holds beatCount. There is no timeout.
- If resetn is asserted mid-COLLECT or mid-EMIT, partial beats are discarded. The next block after reset is processed cleanly.

## Structure
- Shared package holds:
  - block-geometry constants (BITMASK_LENGTH, INDEX_BITWIDTH, BEAT_ELEMENTS defaults)
  - the FSM state enum
  - a helper for beatsNeeded.
- One sub-module: prefix_index_counter. It is combinational and produces the inclusive prefix counts for every mask bit; its top entry gives K.
- The FSM, beat counter, dense buffer and output mux stay in the top module.

## Test plan
All scenarios use the default parameters, with ELEMENT_WIDTH=8 and BEAT_ELEMENTS=4.
- Empty mask: bitmask=16'h0000, no dense beats -> ovalid 1 cycle after mask accept, sparseOutput all 0, numDense=0, denseReady never high.
- Single element: bitmask=16'h0004, one beat {0x00,0x00,0x00,0xAA} (element0=0xAA) -> element 2 = 0xAA, all others 0, numDense=1.
- Full mask: bitmask=16'hFFFF, four beats carrying 0x01..0x10 -> sparseOutput element p = p+1, numDense=16 (5'b10000), ovalid 1 cycle after the 4th beat.
- Partial last beat: bitmask=16'h8001, one beat {junk,junk,0x22,0x11} -> element0=0x11, element15=0x22, junk never appears; 16'h001F needs 2 beats, and 3 junk elements of the 2nd beat are dropped.
- Backpressure and stalls:
  - denseValid toggles 1/0 during COLLECT -> only handshaked beats are counted.
  - iready low for 5 cycles in EMIT -> sparseOutput/numDense stable, maskReady=0; next mask accepted the cycle after iready high.
- Reset mid-operation: assert resetn after 2 of 4 beats for 16'hFFFF -> ovalid=0 and sparseOutput=0 immediately, then 16'h0004 with 0xAA expands correctly.
